picomem_psram_arbiter: RTL
==========================

// Module: picomem_psram_arbiter
// PURPOSE
//   Shares the single PicoMem PSRAM slave port between two PicoMem masters:
//   M0 is the CPU path from the 0xC000_0000 wishbone mux and M1 is the LCD framebuffer line fetcher.
//   M1 has priority so scan-out never underruns. A starvation counter guarantees M0 forward progress.
//   The block sits between the masters and the PSRAM controller's mem_s_* port.
// PARAMETERS
//   STARVE_LIMIT    4             max consecutive M1 grants while M0 is pending; range 1..255
//   TIMEOUT_CYCLES  1024          slave-ready watchdog limit in clk cycles; used only with the macro
//   ERR_RDATA       32'hDEADBEEF  rdata returned on a watchdog abort
// PORTS
//   clk          in   1   system clock (clk_cpu domain)
//   reset        in   1   synchronous reset, active-high
//   m0_valid     in   1   CPU request
//   m0_ready     out  1   CPU transfer done
//   m0_addr      in   32  CPU address
//   m0_wdata     in   32  CPU write data
//   m0_wstrb     in   4   CPU byte strobes; 0 = read
//   m0_rdata     out  32  CPU read data
//   m1_valid/m1_ready/m1_addr/m1_wdata/m1_wstrb/m1_rdata  same widths and meanings, framebuffer master
//   s_valid      out  1   request to PSRAM slave
//   s_ready      in   1   slave done
//   s_addr       out  32  muxed address
//   s_wdata      out  32  muxed write data
//   s_wstrb      out  4   muxed byte strobes
//   s_rdata      in   32  slave read data
//   grant        out  2   one-hot owner: [0]=M0, [1]=M1; 00 = idle
//   timeout_err  out  1   sticky watchdog flag; cleared only by reset
// BEHAVIOUR
//   State machine: IDLE, BUSY0, BUSY1. Reset values: state=IDLE, starve_cnt=0, grant=00, s_valid=0,
//     m*_ready=0, timeout_err=0.
//   IDLE arbitration is registered:
//     - m1_valid and (starve_cnt<STARVE_LIMIT or !m0_valid) -> BUSY1.
//     - otherwise, if m0_valid -> BUSY0.
//   Latency: a request seen in IDLE at cycle N gives s_valid=1 at N+1.
//   BUSYx: s_valid=1. s_addr/s_wdata/s_wstrb are combinationally muxed from the granted master.
//     In IDLE these outputs are 0.
//   mX_ready = s_ready & (state==BUSYx); it is combinational from s_ready, and the non-granted ready is 0.
//   m0_rdata = m1_rdata = s_rdata (broadcast). A master must qualify it with its own ready.
//   On s_ready in BUSYx -> IDLE. At least one IDLE cycle separates transfers, so s_valid drops for
//     >=1 cycle. This lets picorv32 deassert valid after ready.
//   starve_cnt (8 bit):
//     - +1 on each M1 grant while m0_valid=1, saturating at STARVE_LIMIT.
//     - cleared on an M0 grant, or in IDLE when m0_valid=0.
//   Master drops valid while granted (protocol violation): state -> IDLE next cycle, no ready is
//     issued, starve_cnt is unchanged.
//   Simultaneous m0_valid and m1_valid in IDLE with starve_cnt==STARVE_LIMIT: M0 wins.
//   Reset mid-transfer: everything returns to reset values next cycle. The in-flight PSRAM access is
//     abandoned; the slave must tolerate s_valid falling.
//   grant equals the one-hot encoding of state (BUSY0 -> 01, BUSY1 -> 10, IDLE -> 00).
// CONFIGURATION
//   PICOMEM_ARB_TIMEOUT_EN defined:
//     - A 16-bit wait counter is cleared on entry to BUSYx and increments each BUSYx cycle with s_ready=0.
//     - When it reaches TIMEOUT_CYCLES-1: mX_ready=1 for exactly one cycle with mX_rdata=ERR_RDATA,
//       s_valid=0 on that cycle, state -> IDLE, timeout_err set.
//     - A real s_ready on that same cycle wins: normal completion, no error.
//   PICOMEM_ARB_TIMEOUT_EN undefined: the arbiter waits on s_ready indefinitely and timeout_err is tied 0.
// TESTING
//   1. M0 read 0xC000_0010 alone, slave ready after 3 cycles, s_rdata=0x1234_5678
//      -> s_valid rises 1 cycle after m0_valid; m0_ready pulses once with rdata 0x1234_5678; grant=01.
//   2. M0 and M1 both held valid, slave ready in 2 cycles, STARVE_LIMIT=4
//      -> grant sequence M1,M1,M1,M1,M0,M1,...; each grant separated by one IDLE cycle.
//   3. M1 write addr 0xC000_0100, wdata 0xA5A5_A5A5, wstrb 0xF
//      -> s_* carries those exact values; m0_ready stays 0; starve_cnt stays 0 with m0 idle.
//   4. Assert reset while in BUSY1 with s_ready=0
//      -> next cycle: s_valid=0, grant=00, no ready pulse, starve_cnt=0.
//   5. M0 drops valid in BUSY0 before s_ready -> IDLE next cycle, no m0_ready, no s_valid afterwards.
//   6. With the macro, TIMEOUT_CYCLES=16 and s_ready held 0
//      -> m0_ready pulses in the 16th BUSY0 cycle, rdata=0xDEADBEEF, timeout_err=1 until reset.
//      Without the macro -> no ready ever.

Source files
------------

// File: rtl/picomem_psram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : picomem_psram_arbiter
// Purpose  : Two-master PicoMem arbiter for the PSRAM slave port. M1 (LCD
//            framebuffer) has priority, and a starvation counter bounds M0 waits.
//            Optional slave watchdog enabled by `define PICOMEM_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module picomem_psram_arbiter #(
    parameter int          STARVE_LIMIT   = 4,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] ERR_RDATA      = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_valid,
    output logic        m0_ready,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    output logic        m1_ready,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    input  logic        s_ready,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic [31:0] s_rdata,
    output logic [1:0]  grant,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_t;

    localparam logic [7:0] C_STARVE_LIMIT = 8'(STARVE_LIMIT);

    state_t     state_q, state_d;
    logic [7:0] starve_cnt_q, starve_cnt_d;
    logic       timeout_err_q, timeout_err_d;
    logic       busy;
    logic       owner_valid;
    logic       abort;

    assign busy        = (state_q != IDLE);
    assign owner_valid = (state_q == BUSY0) ? m0_valid : m1_valid;

`ifdef PICOMEM_ARB_TIMEOUT_EN
    localparam logic [15:0] C_WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] wait_cnt_q, wait_cnt_d;

    // A genuine s_ready on the final wait cycle takes precedence over the abort.
    assign abort = busy && owner_valid && !s_ready && (wait_cnt_q == C_WAIT_LAST);

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!busy) begin
            wait_cnt_d = 16'd0;
        end else if (!s_ready) begin
            wait_cnt_d = wait_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q <= 16'd0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = (^ERR_RDATA) ^ (TIMEOUT_CYCLES == 0);
    assign abort      = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        starve_cnt_d  = starve_cnt_q;
        timeout_err_d = timeout_err_q;
        case (state_q)
            IDLE: begin
                if (m1_valid && ((starve_cnt_q < C_STARVE_LIMIT) || !m0_valid)) begin
                    state_d = BUSY1;
                    if (m0_valid) begin
                        starve_cnt_d = starve_cnt_q + 8'd1;
                    end
                end else if (m0_valid) begin
                    state_d      = BUSY0;
                    starve_cnt_d = 8'd0;
                end
                if (!m0_valid) begin
                    starve_cnt_d = 8'd0;
                end
            end
            BUSY0, BUSY1: begin
                // Dropped valid, completion and watchdog abort all end the transfer.
                if (!owner_valid || s_ready || abort) begin
                    state_d = IDLE;
                end
                if (abort) begin
                    timeout_err_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            starve_cnt_q  <= 8'd0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            starve_cnt_q  <= starve_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    always_comb begin
        s_addr  = 32'd0;
        s_wdata = 32'd0;
        s_wstrb = 4'd0;
        case (state_q)
            BUSY0: begin
                s_addr  = m0_addr;
                s_wdata = m0_wdata;
                s_wstrb = m0_wstrb;
            end
            BUSY1: begin
                s_addr  = m1_addr;
                s_wdata = m1_wdata;
                s_wstrb = m1_wstrb;
            end
            default: begin
                s_addr  = 32'd0;
                s_wdata = 32'd0;
                s_wstrb = 4'd0;
            end
        endcase
    end

    assign s_valid     = busy && !abort;
    assign m0_ready    = (state_q == BUSY0) && m0_valid && (s_ready || abort);
    assign m1_ready    = (state_q == BUSY1) && m1_valid && (s_ready || abort);
`ifdef PICOMEM_ARB_TIMEOUT_EN
    assign m0_rdata    = abort ? ERR_RDATA : s_rdata;
    assign m1_rdata    = abort ? ERR_RDATA : s_rdata;
`else
    assign m0_rdata    = s_rdata;
    assign m1_rdata    = s_rdata;
`endif
    assign grant       = {state_q == BUSY1, state_q == BUSY0};
    assign timeout_err = timeout_err_q;

endmodule
`default_nettype wire
